// File: rtl/regfile_read_arbiter_pkg.sv
// Shared constants for the register-file read path: address/data widths and the hardwired-zero register.
package regfile_read_arbiter_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;

  localparam logic [REG_AW-1:0] ZERO_ADDR = '0;

endpackage

// File: rtl/regfile_read_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first set req bit scanning upward from ptr, wrapping modulo N.
// Zero latency; an empty req vector yields vld=0 and an all-zero grant.
module rr_priority_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] idx,
  output logic           vld
);

  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!vld && req[j]) begin
        vld    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Round-robin share of one 32:1 register read mux; combinational grant/select, response one cycle later.
// stall suppresses grants without disturbing a response already in flight; requesters hold req until granted.
module regfile_read_arbiter
  import regfile_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [REG_AW*NUM_REQ-1:0] addr,
  input  logic                      stall,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [REG_AW-1:0]         mux_select,
  input  logic [DATA_W-1:0]         mux_data,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy
);

  logic [ID_W-1:0]    ptr;
  logic [NUM_REQ-1:0] req_eff;
  logic [ID_W-1:0]    win_idx;
  logic               win_vld;
  logic [DATA_W-1:0]  rd_word;

  assign req_eff = stall ? '0 : req;
  assign busy    = |req;

  rr_priority_pick #(
    .N   (NUM_REQ),
    .IDW (ID_W)
  ) u_pick (
    .req (req_eff),
    .ptr (ptr),
    .gnt (gnt),
    .idx (win_idx),
    .vld (win_vld)
  );

  assign mux_select = win_vld ? addr[REG_AW*win_idx +: REG_AW] : '0;

  // The zero register is masked here so the mux itself needs no special case.
  assign rd_word = (ZERO_REG && mux_select == ZERO_ADDR) ? '0 : mux_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= win_vld;
      if (win_vld) begin
        rsp_id   <= win_idx;
        rsp_data <= rd_word;
        ptr      <= (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);
      end
    end
  end

endmodule
